// File: rtl/simple_processor_pkg.sv
// Shared definitions for the simple_processor core.
// Instruction layout: op[15:12] | rd[11:9] | rs[8:6] | imm8/addr[7:0].
// The rs and imm/addr fields overlap; each opcode uses only the fields it needs.
package simple_processor_pkg;

  localparam int INSTR_W       = 16;
  localparam int OP_LSB        = 12;
  localparam int OP_W          = 4;
  localparam int RD_LSB        = 9;
  localparam int RS_LSB        = 6;
  localparam int REG_AW        = 3;
  localparam int IMM_W         = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_IN   = 4'h2,
    OP_OUT  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_SHR  = 4'hA,
    OP_JMP  = 4'hB,
    OP_JZ   = 4'hC,
    OP_JNZ  = 4'hD,
    OP_MOV  = 4'hE,
    OP_HALT = 4'hF
  } op_e;

  // Word i lives at bits [i*INSTR_W +: INSTR_W].
  // 0: IN r1 | 1: ADD r2,r1 | 2: OUT r2 | 3: JMP 0 | rest NOP
  localparam logic [DEFAULT_DEPTH*INSTR_W-1:0] DEFAULT_PROG = {
    {12{16'h0000}}, 16'hB000, 16'h3080, 16'h4440, 16'h2200
  };

endpackage

// File: rtl/simple_processor_regfile.sv
// General register file for simple_processor.
// Ports:
//   clk, rst        clock / asynchronous active-high clear of all registers
//   ra_addr/ra_data read port A (combinational)
//   rb_addr/rb_data read port B (combinational)
//   we, wa, wd      single write port, written at the rising clk edge
module simple_processor_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_q [NREGS] = '{default: '0};

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

endmodule

// File: rtl/simple_processor.sv
// simple_processor: single-cycle 32-bit register machine running from an internal ROM.
// One instruction is fetched (combinational ROM read at pc) and executed per rising clk edge.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (pc, registers, data_out, halted -> 0)
//   data_in   operand sampled by IN at the executing edge
//   data_out  registered output, written only by OUT
// Program source: PROG_IMAGE, which defaults to the built-in demo program.
//
// state   | meaning
// run     | halted_q=0: execute ROM[pc] every edge
// halted  | halted_q=1: pc, registers and data_out frozen until reset
module simple_processor
  import simple_processor_pkg::*;
#(
  parameter int    DATA_W     = 32,
  parameter int    NREGS      = 8,
  parameter int    PROG_DEPTH = 16,
  parameter string INIT_FILE  = "",
  parameter logic [PROG_DEPTH*INSTR_W-1:0] PROG_IMAGE = (PROG_DEPTH*INSTR_W)'(DEFAULT_PROG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int PC_W = $clog2(PROG_DEPTH);
  localparam int SH_W = $clog2(DATA_W);

  logic [INSTR_W-1:0] rom [PROG_DEPTH];

  for (genvar i = 0; i < PROG_DEPTH; i++) begin : g_word
    assign rom[i] = PROG_IMAGE[i*INSTR_W +: INSTR_W];
  end

  logic [PC_W-1:0]   pc_q = '0;
  logic [PC_W-1:0]   pc_d;
  logic [DATA_W-1:0] data_out_q = '0;
  logic [DATA_W-1:0] data_out_d;
  logic              halted_q = 1'b0;
  logic              halted_d;

  logic [INSTR_W-1:0] instr;
  op_e                op;
  logic [REG_AW-1:0]  rd, rs;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rd_val, rs_val;
  logic               rf_we;
  logic [DATA_W-1:0]  rf_wd;

  assign instr = rom[pc_q];
  assign op    = op_e'(instr[OP_LSB +: OP_W]);
  assign rd    = instr[RD_LSB +: REG_AW];
  assign rs    = instr[RS_LSB +: REG_AW];
  assign imm   = instr[IMM_W-1:0];

  simple_processor_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rd),
    .ra_data (rd_val),
    .rb_addr (rs),
    .rb_data (rs_val),
    .we      (rf_we),
    .wa      (rd),
    .wd      (rf_wd)
  );

  always_comb begin
    pc_d       = pc_q + PC_W'(1);
    data_out_d = data_out_q;
    halted_d   = halted_q;
    rf_we      = 1'b0;
    rf_wd      = rd_val;
    if (halted_q) begin
      pc_d = pc_q;
    end else begin
      case (op)
        OP_NOP: ;
        OP_LDI: begin rf_we = 1'b1; rf_wd = DATA_W'(imm); end
        OP_IN:  begin rf_we = 1'b1; rf_wd = data_in; end
        OP_OUT: data_out_d = rs_val;
        OP_ADD: begin rf_we = 1'b1; rf_wd = rd_val + rs_val; end
        OP_SUB: begin rf_we = 1'b1; rf_wd = rd_val - rs_val; end
        OP_AND: begin rf_we = 1'b1; rf_wd = rd_val & rs_val; end
        OP_OR:  begin rf_we = 1'b1; rf_wd = rd_val | rs_val; end
        OP_XOR: begin rf_we = 1'b1; rf_wd = rd_val ^ rs_val; end
        OP_SHL: begin rf_we = 1'b1; rf_wd = rd_val << rs_val[SH_W-1:0]; end
        OP_SHR: begin rf_we = 1'b1; rf_wd = rd_val >> rs_val[SH_W-1:0]; end
        OP_MOV: begin rf_we = 1'b1; rf_wd = rs_val; end
        // Jump targets drop address bits above the pc width (wrap modulo depth).
        OP_JMP: pc_d = instr[PC_W-1:0];
        OP_JZ:  if (rs_val == '0) pc_d = instr[PC_W-1:0];
        OP_JNZ: if (rs_val != '0) pc_d = instr[PC_W-1:0];
        OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      data_out_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      data_out_q <= data_out_d;
      halted_q   <= halted_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_simple_processor.sv
module tb_simple_processor;

  logic        clk = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [31:0] out_def, out_shift, out_jump, out_wrap, out_alu;

  int n_cmp = 0;
  int n_bad = 0;

  // LDI r1,0x81; LDI r2,4; SHL r1,r2; OUT r1; SHR r1,r2; OUT r1; HALT
  localparam logic [255:0] SHIFT_PROG = {{9{16'h0000}},
    16'hF000, 16'h3040, 16'hA280, 16'h3040, 16'h9280, 16'h1404, 16'h1281};
  // 0 LDI r3,0 | 1 JZ r3,5 | 2 LDI r5,0x55 | 3 OUT r5 | 4 NOP | 5 LDI r4,7 | 6 OUT r4 | 7 HALT
  // 8 LDI r6,0x66 | 9 OUT r6 (reached only if HALT fails)
  localparam logic [255:0] JUMP_PROG = {{6{16'h0000}},
    16'h3180, 16'h1C66, 16'hF000, 16'h3100, 16'h1807, 16'h0000,
    16'h3140, 16'h1A55, 16'hC0C5, 16'h1600};
  // 0 LDI r1,1 | 1 ADD r2,r1 | 2..14 NOP | 15 OUT r2
  localparam logic [255:0] WRAP_PROG = {16'h3080, {13{16'h0000}}, 16'h4440, 16'h1201};
  // IN r1; IN r2; then MOV r3,r1 / op r3,r2 / OUT r3 for SUB,AND,OR,XOR; JNZ r1,0; HALT
  localparam logic [255:0] ALU_PROG = {
    16'hF000, 16'hD040, 16'h30C0, 16'h8680, 16'hE640, 16'h30C0, 16'h7680, 16'hE640,
    16'h30C0, 16'h6680, 16'hE640, 16'h30C0, 16'h5680, 16'hE640, 16'h2400, 16'h2200};

  simple_processor u_def (.clk(clk), .rst(rst), .data_in(data_in), .data_out(out_def));
  simple_processor #(.PROG_IMAGE(SHIFT_PROG)) u_shift (.clk(clk), .rst(rst), .data_in(data_in), .data_out(out_shift));
  simple_processor #(.PROG_IMAGE(JUMP_PROG))  u_jump  (.clk(clk), .rst(rst), .data_in(data_in), .data_out(out_jump));
  simple_processor #(.PROG_IMAGE(WRAP_PROG))  u_wrap  (.clk(clk), .rst(rst), .data_in(data_in), .data_out(out_wrap));
  simple_processor #(.PROG_IMAGE(ALU_PROG))   u_alu   (.clk(clk), .rst(rst), .data_in(data_in), .data_out(out_alu));

  always #5 if (clk_run) clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [31:0] exp_sub, exp_and, exp_or, exp_xor;
  } alu_vec_t;

  alu_vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; the next rising edge executes ROM[0].
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_000C, 32'h0000_000A, 32'h0000_0002, 32'h0000_0008, 32'h0000_000E, 32'h0000_0006};
    vecs[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0007, 32'h0000_0006};
    vecs[2] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hE100_E100, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[4] = '{32'h0000_0000, 32'h1234_5678, 32'hEDCB_A988, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};

    #1;
    check("reset_def", out_def, 32'h0);
    check("reset_alu", out_alu, 32'h0);

    // Default program, constant input 5: running sum every 4 edges.
    @(negedge clk);
    rst = 1'b0;
    data_in = 32'd5;
    step(2);  check("def_edge2", out_def, 32'd0);
    step(1);  check("def_edge3", out_def, 32'd5);
    step(4);  check("def_edge7", out_def, 32'd10);
    step(4);  check("def_edge11", out_def, 32'd15);
    step(2);

    // Reset with the clock stopped clears data_out without an edge.
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out", out_def, 32'd0);
    #2;
    rst = 1'b0;
    data_in = 32'd7;
    #1;
    check("async_rst_hold", out_def, 32'd0);
    clk_run = 1'b1;
    step(2);  check("restart_edge2", out_def, 32'd0);
    step(1);  check("restart_edge3", out_def, 32'd7);

    // Wrap-around of the running sum.
    do_reset();
    data_in = 32'hFFFF_FFFF;
    step(3);  check("wrap_sum1", out_def, 32'hFFFF_FFFF);
    step(4);  check("wrap_sum2", out_def, 32'hFFFF_FFFE);

    // Shift program.
    do_reset();
    step(3);  check("shl_before_out", out_shift, 32'h0);
    step(1);  check("shl_out", out_shift, 32'h0000_0810);
    step(2);  check("shr_out", out_shift, 32'h0000_0081);

    // JZ skips the OUT of 0x55; HALT freezes the result.
    do_reset();
    step(3);  check("jz_skip", out_jump, 32'h0);
    step(1);  check("jz_target_out", out_jump, 32'd7);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check($sformatf("halt_stable_%0d", i), out_jump, 32'd7);
    end

    // 16-word program: pc wraps 15 -> 0.
    do_reset();
    step(15); check("pcwrap_edge15", out_wrap, 32'd0);
    step(1);  check("pcwrap_edge16", out_wrap, 32'd1);
    step(16); check("pcwrap_edge32", out_wrap, 32'd2);

    // ALU vectors: each pass reads a,b and outputs sub/and/or/xor; a==0 ends in HALT.
    do_reset();
    for (int v = 0; v < 5; v++) begin
      data_in = vecs[v].a;
      step(1);
      data_in = vecs[v].b;
      step(1);
      step(3);  check($sformatf("alu%0d_sub", v), out_alu, vecs[v].exp_sub);
      step(3);  check($sformatf("alu%0d_and", v), out_alu, vecs[v].exp_and);
      step(3);  check($sformatf("alu%0d_or", v),  out_alu, vecs[v].exp_or);
      step(3);  check($sformatf("alu%0d_xor", v), out_alu, vecs[v].exp_xor);
      step(1);
    end
    data_in = 32'h0000_DEAD;
    step(12); check("alu_halt_frozen", out_alu, 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
